// File: rtl/mk14_pkg.sv
// Shared MK14 display constants and the scan controller state encoding.
package mk14_pkg;

   localparam int unsigned MK14_DIGITS = 8;
   localparam int unsigned MK14_SEG_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ON    = 2'd2,
      BLANK = 2'd3
   } scan_state_t;

endpackage

// File: rtl/mk14_display_scan.sv
// Multiplexed 8-digit 7-segment scan controller with per-frame snapshot,
// inter-digit blanking and 16-step PWM brightness.
module mk14_display_scan
   import mk14_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES   = 12000,
   parameter int unsigned BLANK_CYCLES   = 12,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                enable,
   input  logic [MK14_DIGITS*MK14_SEG_W-1:0]   display,
   input  logic [3:0]                          brightness,
   output logic [MK14_SEG_W-1:0]               seg,
   output logic [MK14_DIGITS-1:0]              dig,
   output logic                                frame_start
);

   localparam int unsigned SLOT_LEN = DWELL_CYCLES / 16;
   localparam int unsigned CNT_W    = $clog2(DWELL_CYCLES);
   localparam int unsigned SUB_W    = $clog2(SLOT_LEN);
   localparam int unsigned IDX_W    = $clog2(MK14_DIGITS);
   localparam int unsigned SNAP_W   = MK14_DIGITS * MK14_SEG_W;

   localparam logic [MK14_SEG_W-1:0]  SEG_OFF = {MK14_SEG_W{SEG_ACTIVE_LOW}};
   localparam logic [MK14_DIGITS-1:0] DIG_OFF = {MK14_DIGITS{DIG_ACTIVE_LOW}};

   scan_state_t             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SUB_W-1:0]        sub_q, sub_d;
   logic [3:0]              slot_q, slot_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [SNAP_W-1:0]       snap_q, snap_d;
   logic [3:0]              bri_q, bri_d;
   logic [MK14_SEG_W-1:0]   seg_d;
   logic [MK14_DIGITS-1:0]  dig_d;
   logic                    frame_start_d;

   // Output registers are fed from next-state values so each output
   // reflects the state being entered on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sub_q       <= '0;
         slot_q      <= '0;
         idx_q       <= '0;
         snap_q      <= '0;
         bri_q       <= '0;
         seg         <= SEG_OFF;
         dig         <= DIG_OFF;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sub_q       <= sub_d;
         slot_q      <= slot_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         bri_q       <= bri_d;
         seg         <= seg_d ^ SEG_OFF;
         dig         <= dig_d ^ DIG_OFF;
         frame_start <= frame_start_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + CNT_W'(1);
      sub_d         = sub_q;
      slot_d        = slot_q;
      idx_d         = idx_q;
      snap_d        = snap_q;
      bri_d         = bri_q;
      seg_d         = '0;
      dig_d         = '0;
      frame_start_d = 1'b0;

      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         sub_d   = '0;
         slot_d  = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = LOAD;
               cnt_d   = '0;
            end
            LOAD: begin
               state_d = ON;
               cnt_d   = '0;
               sub_d   = '0;
               slot_d  = '0;
            end
            ON: begin
               if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                  state_d = BLANK;
                  cnt_d   = '0;
               end else if (sub_q == SUB_W'(SLOT_LEN - 1)) begin
                  sub_d  = '0;
                  slot_d = slot_q + 4'd1;
               end else begin
                  sub_d = sub_q + SUB_W'(1);
               end
            end
            BLANK: begin
               if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                  cnt_d  = '0;
                  sub_d  = '0;
                  slot_d = '0;
                  if (idx_q == IDX_W'(MK14_DIGITS - 1)) begin
                     state_d = LOAD;
                  end else begin
                     state_d = ON;
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Snapshot on LOAD entry so the CPU cannot tear a frame.
      if (state_d == LOAD) begin
         snap_d        = display;
         bri_d         = brightness;
         idx_d         = '0;
         frame_start_d = 1'b1;
      end

      if (state_d == ON) begin
         dig_d = MK14_DIGITS'(1) << idx_d;
         if ({1'b0, slot_d} < ({1'b0, bri_d} + 5'd1)) begin
            seg_d = snap_d[{idx_d, 3'b000} +: MK14_SEG_W];
         end
      end
   end

endmodule

// File: tb/tb_mk14_display_scan.sv
// Scoreboard bench for mk14_display_scan using a frame-position reference model.
module tb_mk14_display_scan;

   localparam int D     = 32;
   localparam int B     = 2;
   localparam int SLOT  = D + B;
   localparam int FRAME = 8 * SLOT + 1;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [63:0] display;
   logic [3:0]  brightness;
   logic [7:0]  seg;
   logic [7:0]  dig;
   logic        frame_start;

   mk14_display_scan #(
      .DWELL_CYCLES  (D),
      .BLANK_CYCLES  (B),
      .SEG_ACTIVE_LOW(1'b1),
      .DIG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .display    (display),
      .brightness (brightness),
      .seg        (seg),
      .dig        (dig),
      .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] seg;
      logic [7:0] dig;
      logic       fs;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_fs = -1;
   bit          broke = 1'b1;
   logic        prev_fs = 1'b0;
   bit          m_active = 1'b0;
   int          m_pos = 0;
   logic [63:0] m_snap = '0;
   logic [3:0]  m_bri = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, want);
      end
   endtask

   // Predict the post-edge outputs, advance one clock, then compare.
   task automatic step();
      exp_t e;
      int   p, d, r;
      e.seg = 8'hFF;
      e.dig = 8'hFF;
      e.fs  = 1'b0;
      if (!rst_n || !enable) begin
         m_active = 1'b0;
      end else begin
         if (!m_active) begin
            m_active = 1'b1;
            m_pos    = 0;
         end else begin
            m_pos = (m_pos + 1) % FRAME;
         end
         if (m_pos == 0) begin
            e.fs   = 1'b1;
            m_snap = display;
            m_bri  = brightness;
         end else begin
            p = m_pos - 1;
            d = p / SLOT;
            r = p % SLOT;
            if (r < D) begin
               e.dig = ~(8'h01 << d);
               if ((r / (D / 16)) <= int'(m_bri)) e.seg = ~m_snap[d*8 +: 8];
            end
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      e = exp_q.pop_front();
      check("seg", 64'(seg), 64'(e.seg));
      check("dig", 64'(dig), 64'(e.dig));
      check("frame_start", 64'(frame_start), 64'(e.fs));
      check("dig_onehot", 64'($onehot0(~dig)), 64'd1);
      check("fs_width", 64'(frame_start & prev_fs), 64'd0);
      if (frame_start) begin
         if (last_fs >= 0 && !broke) check("frame_period", 64'(cyc - last_fs), 64'(FRAME));
         last_fs = cyc;
         broke   = 1'b0;
      end
      prev_fs = frame_start;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Step until the model sits inside the ON dwell of digit dg (bounded).
   task automatic wait_digit(input int dg);
      int budget = 2 * FRAME;
      while (!(m_active && m_pos > dg * SLOT + 4 && m_pos <= dg * SLOT + D / 2) && budget > 0) begin
         step();
         budget--;
      end
      check("wait_digit_timeout", 64'(budget == 0), 64'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b1;
      display    = 64'h0706050403020100;
      brightness = 4'd15;
      run(5);
      check("reset_seg", 64'(seg), 64'hFF);
      check("reset_dig", 64'(dig), 64'hFF);

      rst_n = 1'b1;
      step();
      check("first_fs", 64'(frame_start), 64'd1);
      step();
      check("first_dig", 64'(dig), 64'hFE);
      check("first_seg", 64'(seg), 64'hFF);
      run(2 * FRAME);

      brightness = 4'd3;
      run(FRAME + 10);
      brightness = 4'd0;
      run(FRAME + 10);
      brightness = 4'd15;
      run(FRAME);

      wait_digit(3);
      display = 64'hFFFF_FFFF_FFFF_FFFF;
      run(FRAME + 40);

      display = 64'h1122334455667788;
      wait_digit(5);
      enable = 1'b0;
      broke  = 1'b1;
      step();
      check("drop_dig", 64'(dig), 64'hFF);
      check("drop_seg", 64'(seg), 64'hFF);
      run(3);
      enable = 1'b1;
      step();
      check("reenable_fs", 64'(frame_start), 64'd1);
      run(FRAME + 10);

      wait_digit(2);
      rst_n = 1'b0;
      broke = 1'b1;
      step();
      check("midframe_reset_dig", 64'(dig), 64'hFF);
      rst_n = 1'b1;
      run(FRAME + 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mk14_display_scan.md
# mk14_display_scan

Time-multiplexing scan controller that drives the MK14 SoC's 64-bit `display` bus (8 digits × 8 segment bits) onto a physical 8-digit multiplexed 7-segment display. It sits beside `mk14_soc` in the board top and owns the shared segment lines, granting them to one digit at a time. It inserts ghost-suppression blanking between digits and applies per-frame PWM brightness. It snapshots the display bus once per frame so the CPU never causes mid-frame tearing.

## Interface
Parameters:
- `DWELL_CYCLES`, 12000: clocks per digit slot (1 ms at 12 MHz); must be a multiple of 16 and ≥ 32.
- `BLANK_CYCLES`, 12: clocks of all-off between digits; must be ≥ 1 and < `DWELL_CYCLES`.
- `SEG_ACTIVE_LOW`, 1: 1 means segment outputs are inverted (lit = 0).
- `DIG_ACTIVE_LOW`, 1: 1 means digit enables are inverted (selected = 0).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  scanning allowed.
- `display`  in  64  digit i segments = `display[i*8+7 -: 8]`; bit 7 is the decimal point.
- `brightness`  in  4  0..15; on-fraction is (brightness+1)/16.
- `seg`  out  8  segment drive, polarity per `SEG_ACTIVE_LOW`.
- `dig`  out  8  one-hot digit drive, polarity per `DIG_ACTIVE_LOW`.
- `frame_start`  out  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
- FSM states: IDLE, LOAD, ON, BLANK.
- IDLE: all outputs inactive. Go to LOAD when `enable` = 1.
- LOAD (1 cycle): latch `display` → `snap[63:0]` and `brightness` → `bri_q`. Set digit index = 0, pulse `frame_start`, go to ON.
- ON (`DWELL_CYCLES` clocks):
  - `dig` selects the current index.
  - The dwell is split into 16 slots of `DWELL_CYCLES/16` clocks.
  - `seg` = `snap` byte of the current index while slot < `bri_q`+1; otherwise all segments are inactive.
  - At the end of the dwell, go to BLANK.
- BLANK (`BLANK_CYCLES` clocks): `seg` and `dig` are inactive. At the end:
  - index < 7: index+1, go to ON.
  - index = 7: go to LOAD (wrap; new snapshot).
- `enable` deasserted in any state: next state is IDLE and outputs are inactive on the following edge. The current frame is abandoned. Re-enable always restarts at LOAD / digit 0.
- Changes on `display` and `brightness` during a frame are ignored until the next LOAD.
- All counters are unsigned. The dwell counter needs `$clog2(DWELL_CYCLES)` bits; the slot index is the top 4 bits of dwell_count/(DWELL_CYCLES/16). Counters never overflow; they are reloaded at each state entry.
- Polarity is applied only at the output registers. Internal logic is active-high.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Reset (`rst_n` = 0 at a clock edge):
  - state = IDLE, index = 0, counters = 0, `snap` = 0.
  - `frame_start` = 0.
  - `seg` = 8'hFF, `dig` = 8'hFF (inactive levels with default params).
  - Reset mid-frame takes effect on that edge.
- From `rst_n` high with `enable` high: LOAD on edge 1, `frame_start` visible after edge 1, `dig` for digit 0 active after edge 2.
- Frame period = 8·(`DWELL_CYCLES` + `BLANK_CYCLES`) + 1 clocks (default 96097).
- `frame_start` pulses exactly once per frame, 1 cycle wide.
- `dig` is never multi-hot, and `dig` never changes in the same cycle that `seg` shows non-blank data for a different digit. BLANK guarantees at least `BLANK_CYCLES` of separation.

## Structure
- Shared package `mk14_pkg`:
  - `MK14_DIGITS` = 8 and `MK14_SEG_W` = 8.
  - typedef `scan_state_t` enum {IDLE, LOAD, ON, BLANK}.
  - These are reused by the SoC display latch and by testbenches.
- Single module with no sub-module; the dwell counter, slot compare and FSM are small enough to live inline.
- Board top instantiates with `DWELL_CYCLES` = 12000 for 12 MHz.

## Test plan
Run with `DWELL_CYCLES` = 32 and `BLANK_CYCLES` = 2 unless stated.
- Reset hold:
  - Stimulus: `rst_n` = 0 for 5 clocks, `enable` = 1.
  - Response: `seg` = FF, `dig` = FF, `frame_start` = 0 throughout.
  - After release: `frame_start` high on cycle 1 only; `dig` = 8'hFE from cycle 2.
- Scan order and data:
  - Stimulus: `display` = 64'h0706050403020100, `brightness` = 15.
  - Response: digits 0..7 in order; `seg` = ~8'h00, ~8'h01, ... ~8'h07 for 32 clocks each.
  - Each digit is separated by 2 clocks of `dig` = `seg` = FF; frame period = 273 clocks.
- Brightness PWM:
  - Stimulus: `brightness` = 3.
  - Response: within each dwell, segments lit for the first 8 clocks (4 slots × 2) and blank for the remaining 24.
  - With `brightness` = 0: lit for 2 clocks per digit.
- Snapshot:
  - Stimulus: change `display` to all 8'hFF mid-frame (during digit 3).
  - Response: digits 3..7 still show the old bytes; new values appear from digit 0 after the next `frame_start`.
- Enable drop:
  - Stimulus: deassert `enable` during digit 5 ON.
  - Response: next edge gives `seg` = `dig` = FF and state IDLE.
  - Re-assert `enable`: `frame_start` pulse, then digit 0 with a fresh snapshot.
- Assertions run throughout all tests:
  - `dig` is one-hot or all-inactive.
  - `frame_start` is never 2 cycles wide.
